pc_next_gen: RTL and testbench
==============================

# pc_next_gen

Parametrised program-counter stage for the fetch front end; successor to the plain registered PC latch. Holds the current fetch PC and selects the next one from sequential increment, EX-stage redirect, call target or return-address-stack (RAS) pop, with a fetch stall. Sits between the branch/EX resolution logic and the instruction-memory address port.

## Interface
- PC_W, 16: PC width in bits.
- RST_VEC, 0: PC value loaded by reset.
- INC, 1: sequential increment (instruction size in address units).
- RAS_DEPTH, 4: return-address-stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; call/ret ignored while high.
- redirect_valid  in  1  load redirect_pc next cycle.
- redirect_pc  in  PC_W  redirect target.
- call_valid  in  1  current PC is a call; jump to call_target, push npc.
- call_target  in  PC_W  call destination.
- ret_valid  in  1  current PC is a return; jump to RAS top, pop.
- pc  out  PC_W  current fetch PC (registered).
- npc  out  PC_W  pc + INC, combinational, modulo 2^PC_W.
- pc_valid  out  1  PC is a legal fetch address (registered).
- ras_empty  out  1  RAS count == 0 (registered-state derived).
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: a push overwrote the oldest entry.
- ras_unf  out  1  one-cycle pulse: ret with empty RAS.

## Operation
- reset low (any time, asynchronous): pc=RST_VEC, pc_valid=0, RAS count=0, top pointer=0, ras_ovf=0, ras_unf=0; RAS storage contents need not be cleared.
- First rising edge after reset release: pc_valid←1, pc stays RST_VEC (no increment). Normal operation from the next edge.
- Next-PC priority per edge while pc_valid=1:
  1. redirect_valid: pc←redirect_pc. Overrides stall; call/ret that cycle discarded, RAS untouched.
  2. stall: pc held, RAS untouched, call/ret discarded.
  3. call_valid and ret_valid: pc←call_target; top entry replaced by npc (count unchanged); if empty, plain push.
  4. call_valid: pc←call_target; push npc.
  5. ret_valid: non-empty → pc←top entry, pop; empty → pc←npc, ras_unf pulses 1 cycle, count stays 0.
  6. otherwise pc←npc.
- Push when full: circular overwrite of oldest entry, count stays RAS_DEPTH, ras_ovf←1 (sticky until reset).
- RAS is circular buffer indexed by log2(RAS_DEPTH)-bit top pointer; pointer wraps modulo RAS_DEPTH.
- npc wraps: pc=2^PC_W−INC gives npc=0; no flag.

## Timing
- Single-cycle latency: control inputs sampled at edge N affect pc visible after edge N.
- npc combinational from pc only; no combinational path from any input to any output.
- ras_empty/ras_full reflect count after the same edge that updates pc.
- ras_unf high exactly the cycle after the offending edge, then 0 unless repeated.
- Reset assertion mid-operation takes effect immediately, without a clock; all outputs at reset values while reset low.

## Test plan
- Reset/boot: RST_VEC=0x0100, release reset, no controls → pc_valid 0→1 on first edge with pc=0x0100, then 0x0101, 0x0102 on subsequent edges.
- Stall vs redirect: stall high 3 cycles at pc=0x0010 → pc holds 0x0010; during stall assert redirect_valid, redirect_pc=0x0400 → pc=0x0400 next cycle.
- Call/ret: at pc=0x0020 call_valid, call_target=0x0200 → pc=0x0200, ras_empty=0; at 0x0205 ret_valid → pc=0x0021, ras_empty=1.
- RAS overflow: RAS_DEPTH=4, five nested calls pushing 0x11..0x15 → ras_full=1, ras_ovf=1; five rets → pc 0x15,0x14,0x13,0x12, then 5th ret gives ras_unf pulse and pc=npc.
- Simultaneous call+ret with one entry 0x0031 at pc=0x0050, call_target=0x0300 → pc=0x0300, top=0x0051, count 1; following ret → pc=0x0051.
- Wrap + async reset: PC_W=16, pc=0xFFFF, INC=1 → pc=0x0000; assert reset mid-cycle with RAS non-empty → pc=RST_VEC, pc_valid=0, ras_empty=1, ras_ovf=0 before next edge.

Source files
------------

// File: rtl/pc_next_gen.sv
// Fetch program counter with redirect/stall priority and a circular return-address stack.
// pc updates one edge after controls are sampled; npc is combinational from pc only.
module pc_next_gen #(
   parameter int unsigned        PC_W      = 16,
   parameter logic [PC_W-1:0]    RST_VEC   = '0,
   parameter int unsigned        INC       = 1,
   parameter int unsigned        RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            call_valid,
   input  logic [PC_W-1:0] call_target,
   input  logic            ret_valid,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] npc,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  pc_q, pc_d;
   logic             pc_valid_q, pc_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] top_q, top_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic             empty, full;

   // top_q names the next free slot; the top entry lives at top_q-1.
   assign npc   = pc_q + PC_W'(INC);
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_MAX);

   always_comb begin
      pc_d       = pc_q;
      pc_valid_d = 1'b1;
      cnt_d      = cnt_q;
      top_d      = top_q;
      ovf_d      = ovf_q;
      unf_d      = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = top_q;
      if (!pc_valid_q) begin
         pc_d = pc_q;
      end else if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (call_valid && ret_valid && !empty) begin
         pc_d   = call_target;
         wr_en  = 1'b1;
         wr_idx = top_q - PTR_ONE;
      end else if (call_valid) begin
         // A push onto a full stack lands on the oldest slot and wraps the pointer.
         pc_d   = call_target;
         wr_en  = 1'b1;
         wr_idx = top_q;
         top_d  = top_q + PTR_ONE;
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (ret_valid) begin
         if (!empty) begin
            pc_d  = ras_q[top_q - PTR_ONE];
            top_d = top_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            pc_d  = npc;
            unf_d = 1'b1;
         end
      end else begin
         pc_d = npc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RST_VEC;
         pc_valid_q <= 1'b0;
         cnt_q      <= '0;
         top_q      <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         cnt_q      <= cnt_d;
         top_q      <= top_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         ras_q[wr_idx] <= npc;
      end
   end

   assign pc        = pc_q;
   assign pc_valid  = pc_valid_q;
   assign ras_empty = empty;
   assign ras_full  = full;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_next_gen.sv
// Bench for pc_next_gen: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the PC and return stack.
module tb_pc_next_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect_valid, call_valid, ret_valid;
   logic [15:0] redirect_pc, call_target;
   logic [15:0] pc, npc;
   logic        pc_valid, ras_empty, ras_full, ras_ovf, ras_unf;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   pc_next_gen #(.PC_W(16), .RST_VEC(16'h0100), .INC(1), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .call_valid(call_valid), .call_target(call_target), .ret_valid(ret_valid),
      .pc(pc), .npc(npc), .pc_valid(pc_valid), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   // Reference model: a queue whose back is the top of the return stack.
   logic [15:0] m_pc    = 16'h0100;
   bit          m_valid = 1'b0;
   bit          m_ovf   = 1'b0;
   bit          m_unf   = 1'b0;
   logic [15:0] m_ras[$];

   function automatic void m_push(input logic [15:0] v);
      if (m_ras.size() == 4) begin
         void'(m_ras.pop_front());
         m_ovf = 1'b1;
      end
      m_ras.push_back(v);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 16'h0100; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         m_ras.delete();
      end else begin
         logic [15:0] nx;
         nx    = m_pc + 16'd1;
         m_unf = 1'b0;
         if (!m_valid) m_valid = 1'b1;
         else if (redirect_valid) m_pc = redirect_pc;
         else if (stall) m_pc = m_pc;
         else if (call_valid) begin
            if (ret_valid && m_ras.size() > 0) m_ras[m_ras.size()-1] = nx;
            else m_push(nx);
            m_pc = call_target;
         end else if (ret_valid) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = nx; m_unf = 1'b1; end
         end else m_pc = nx;
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Literal expectation applied both to the DUT and to the model.
   task automatic lit(input string nm, input logic [15:0] dv, input logic [15:0] mv,
                      input logic [15:0] exp);
      chk({nm, "_dut"}, dv, exp);
      chk({nm, "_model"}, mv, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", pc, m_pc);
         chk("npc", npc, m_pc + 16'd1);
         chk("pc_valid", 16'(pc_valid), 16'(m_valid));
         chk("ras_empty", 16'(ras_empty), 16'(m_ras.size() == 0));
         chk("ras_full", 16'(ras_full), 16'(m_ras.size() == 4));
         chk("ras_ovf", 16'(ras_ovf), 16'(m_ovf));
         chk("ras_unf", 16'(ras_unf), 16'(m_unf));
      end
   end

   task automatic idle();
      stall = 0; redirect_valid = 0; call_valid = 0; ret_valid = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input logic [15:0] a);
      redirect_valid = 1; redirect_pc = a; cyc(1); idle();
   endtask

   task automatic call(input logic [15:0] t);
      call_valid = 1; call_target = t; cyc(1); idle();
   endtask

   task automatic ret();
      ret_valid = 1; cyc(1); idle();
   endtask

   initial begin
      reset = 1'b0; idle(); redirect_pc = '0; call_target = '0;
      cyc(2);
      lit("rst_pc", pc, m_pc, 16'h0100);
      lit("rst_valid", 16'(pc_valid), 16'(m_valid), 16'h0);
      chk_en = 1'b1;
      reset  = 1'b1;
      cyc(1);
      lit("boot_valid", 16'(pc_valid), 16'(m_valid), 16'h1);
      lit("boot_pc0", pc, m_pc, 16'h0100);
      cyc(1); lit("boot_pc1", pc, m_pc, 16'h0101);
      cyc(1); lit("boot_pc2", pc, m_pc, 16'h0102);

      go(16'h0010);
      stall = 1; cyc(3);
      lit("stall_hold", pc, m_pc, 16'h0010);
      redirect_valid = 1; redirect_pc = 16'h0400; cyc(1); idle();
      lit("stall_redir", pc, m_pc, 16'h0400);

      go(16'h0020);
      call(16'h0200);
      lit("call_pc", pc, m_pc, 16'h0200);
      lit("call_empty", 16'(ras_empty), 16'(m_ras.size() == 0), 16'h0);
      cyc(5);
      lit("seq_pc", pc, m_pc, 16'h0205);
      ret();
      lit("ret_pc", pc, m_pc, 16'h0021);
      lit("ret_empty", 16'(ras_empty), 16'(m_ras.size() == 0), 16'h1);

      go(16'h0010);
      for (int i = 1; i <= 5; i++) call(16'h0010 + 16'(i));
      lit("ovf_full", 16'(ras_full), 16'(m_ras.size() == 4), 16'h1);
      lit("ovf_flag", 16'(ras_ovf), 16'(m_ovf), 16'h1);
      for (int i = 0; i < 4; i++) begin
         ret();
         lit("ovf_ret", pc, m_pc, 16'h0015 - 16'(i));
      end
      ret();
      lit("unf_pc", pc, m_pc, 16'h0013);
      lit("unf_pulse", 16'(ras_unf), 16'(m_unf), 16'h1);
      cyc(1);
      lit("unf_clear", 16'(ras_unf), 16'(m_unf), 16'h0);

      go(16'h0030);
      call(16'h0050);
      call_valid = 1; ret_valid = 1; call_target = 16'h0300; cyc(1); idle();
      lit("cr_pc", pc, m_pc, 16'h0300);
      lit("cr_full", 16'(ras_full), 16'(m_ras.size() == 4), 16'h0);
      lit("cr_empty", 16'(ras_empty), 16'(m_ras.size() == 0), 16'h0);
      ret();
      lit("cr_ret", pc, m_pc, 16'h0051);

      go(16'hFFFF);
      lit("wrap_npc", npc, m_pc + 16'd1, 16'h0000);
      cyc(1);
      lit("wrap_pc", pc, m_pc, 16'h0000);
      call(16'h0700);
      #2 reset = 1'b0;
      #1;
      lit("arst_pc", pc, m_pc, 16'h0100);
      lit("arst_valid", 16'(pc_valid), 16'(m_valid), 16'h0);
      lit("arst_empty", 16'(ras_empty), 16'(m_ras.size() == 0), 16'h1);
      lit("arst_ovf", 16'(ras_ovf), 16'(m_ovf), 16'h0);
      cyc(1);
      reset = 1'b1;

      for (int n = 0; n < 1500; n++) begin
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         stall          = ($urandom_range(0, 6) == 0);
         call_valid     = ($urandom_range(0, 3) == 0);
         ret_valid      = ($urandom_range(0, 3) == 0);
         call_target    = 16'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #3 reset = 1'b0;
            cyc(1);
            reset = 1'b1;
         end else begin
            cyc(1);
         end
      end
      idle();
      cyc(1);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
